// File: rtl/multicycle_data_path_if.sv
// multicycle_data_path_if: instruction and data memory req/ack buses of the multicycle core
interface multicycle_data_path_if #(
    parameter int DW = 8,
    parameter int AW = 12,
    parameter int IW = 22
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [IW-1:0] imem_rdata;
    logic          dmem_req;
    logic          dmem_we;
    logic [DW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic          dmem_ack;
    logic [DW-1:0] dmem_rdata;
    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  imem_ack, imem_rdata, dmem_ack, dmem_rdata
    );
    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output imem_ack, imem_rdata, dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/multicycle_data_path.sv
// multicycle_data_path: parametrised multicycle core with handshaked instruction/data memories
module multicycle_data_path #(
    parameter int DW  = 8,
    parameter int AW  = 12,
    parameter int RAW = 3,
    localparam int LW = (AW > DW) ? AW : DW,
    localparam int IW = 4 + 2 * RAW + LW
) (
    input  logic                  clk,
    input  logic                  rst,
    multicycle_data_path_if.master bus,
    output logic [AW-1:0]         pc_out,
    output logic                  retire,
    output logic                  halted
);
    typedef enum logic [2:0] {S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                           OP_ADDI = 4'd4, OP_LD = 4'd5, OP_ST = 4'd6, OP_JMP = 4'd7,
                           OP_BZ = 4'd8, OP_HALT = 4'd15;
    state_t state, nxt;
    logic [AW-1:0] pc, pc_inc, br_off;
    logic [IW-1:0] ir;
    logic [DW-1:0] a, b, res, alu;
    logic [DW-1:0] rf [2**RAW];
    logic [3:0] op;
    logic [RAW-1:0] rd, rs, rt;
    logic [DW-1:0] imm;
    logic [AW-1:0] tgt;
    assign op     = ir[IW-1 -: 4];
    assign rd     = ir[IW-5 -: RAW];
    assign rs     = ir[IW-5-RAW -: RAW];
    assign rt     = ir[RAW-1:0];
    assign imm    = ir[DW-1:0];
    assign tgt    = ir[AW-1:0];
    assign pc_inc = pc + AW'(1);
    assign br_off = AW'(signed'(imm));
    always_comb begin
        alu = op == OP_ADD ? a + b :
              op == OP_SUB ? a - b :
              op == OP_AND ? a & b :
              op == OP_OR  ? a | b : a + imm;
    end
    always_comb begin
        nxt = state;
        case (state)
            S_BOOT:   nxt = S_FETCH;
            S_FETCH:  nxt = bus.imem_ack ? S_DECODE : S_FETCH;
            S_DECODE: nxt = op == OP_HALT ? S_HALT : op > OP_BZ ? S_FETCH : S_EXEC;
            S_EXEC:   nxt = op <= OP_ADDI ? S_WB : op <= OP_ST ? S_MEM : S_FETCH;
            S_MEM:    nxt = !bus.dmem_ack ? S_MEM : op == OP_LD ? S_WB : S_FETCH;
            S_WB:     nxt = S_FETCH;
            default:  nxt = state;
        endcase
    end
    // request/status lines decode straight from state so reset drops them asynchronously
    always_comb begin
        bus.imem_req  = state == S_FETCH;
        bus.imem_addr = pc;
        bus.dmem_req  = state == S_MEM;
        halted        = state == S_HALT;
        pc_out        = pc;
        retire        = (state == S_DECODE && op > OP_BZ) ||
                        (state == S_EXEC && (op == OP_JMP || op == OP_BZ)) ||
                        (state == S_MEM && op == OP_ST && bus.dmem_ack) ||
                        state == S_WB;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_BOOT;
            pc             <= '0;
            ir             <= '0;
            a              <= '0;
            b              <= '0;
            res            <= '0;
            bus.dmem_we    <= 1'b0;
            bus.dmem_addr  <= '0;
            bus.dmem_wdata <= '0;
            for (int i = 0; i < 2**RAW; i++) rf[i] <= '0;
        end else begin
            state <= nxt;
            if (state == S_FETCH && bus.imem_ack) ir <= bus.imem_rdata;
            if (state == S_DECODE) begin
                a <= rf[rs];
                b <= rf[(op == OP_ST || op == OP_BZ) ? rd : rt];
            end
            if (state == S_EXEC) begin
                res            <= alu;
                bus.dmem_we    <= op == OP_ST;
                bus.dmem_addr  <= a + imm;
                bus.dmem_wdata <= b;
            end
            if (state == S_MEM && bus.dmem_ack && op == OP_LD) res <= bus.dmem_rdata;
            if (state == S_WB && rd != '0) rf[rd] <= res;
            if (state == S_EXEC && op == OP_JMP) pc <= tgt;
            else if (state == S_EXEC && op == OP_BZ && b == '0) pc <= pc_inc + br_off;
            else if (retire && op != OP_HALT) pc <= pc_inc;
        end
    end
endmodule
